// File: rtl/encoder_8b_10b_multi_if.sv
// Stream bundle for the multi-lane 8b/10b encoder: input word handshake,
// output symbol handshake and running-disparity observation.
interface encoder_8b_10b_multi_if #(
    parameter int LANES = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*LANES-1:0]    data_in;
    logic [LANES-1:0]      k_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [10*LANES-1:0]   data_out;
    logic [LANES-1:0]      code_err;
    logic                  rd_out;

    // Producer/consumer side (drives input word, accepts encoded word)
    modport master (
        output in_valid, data_in, k_in, out_ready,
        input  in_ready, out_valid, data_out, code_err, rd_out
    );

    // Encoder side
    modport slave (
        input  in_valid, data_in, k_in, out_ready,
        output in_ready, out_valid, data_out, code_err, rd_out
    );
endinterface

// File: rtl/encoder_8b_10b_multi.sv
// Multi-lane 8b/10b encoder with a single registered output stage.
// Lanes are encoded in order 0..LANES-1 within a word, each lane starting
// from the disparity left by the previous one; lane 0 starts from the
// registered running disparity.
module encoder_8b_10b_multi #(
    parameter int LANES = 2
) (
    input logic                    clk,
    input logic                    rst,
    encoder_8b_10b_multi_if.slave  bus
);

    // RD- column of the 5b/6b table, abcdei order
    function automatic logic [5:0] code6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // RD- column of the 3b/4b data table (primary D.x.7), fghj order
    function automatic logic [3:0] code4_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // Encode one lane: returns {code_err, rd_after, abcdei, fghj}
    function automatic logic [11:0] enc_lane(input logic [7:0] b, input logic k,
                                             input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       valid_k, bad, rd_mid, rd_end, a7, k_bal;
        logic       unbal6, flip6, unbal4, flip4;
        logic [5:0] b6, s6;
        logic [3:0] b4, s4;
        x = b[4:0];
        y = b[7:5];
        valid_k = (x == 5'd28) ||
                  ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                   (x == 5'd29) || (x == 5'd30)));
        bad = k && !valid_k;
        // Illegal control codes are replaced by K28.5
        if (bad) begin
            x = 5'd28;
            y = 3'd5;
        end
        b6 = (k && (x == 5'd28)) ? 6'b001111 : code6_neg(x);
        unbal6 = ($countones(b6) != 3);
        // D.7 is balanced but still has distinct RD-/RD+ forms
        flip6 = unbal6 || (b6 == 6'b111000);
        s6 = (rd && flip6) ? ~b6 : b6;
        rd_mid = rd ^ unbal6;
        // Alternate D.x.A7 avoids a run of five in e,i,f,g,h; K.x.7 always uses it
        a7 = (y == 3'd7) &&
             (k || (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              (rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        // K.x.1/2/5/6 use the inverse of the data code when the 6b left RD-
        k_bal = k && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6));
        b4 = a7 ? 4'b0111 : code4_neg(y);
        if (k_bal) begin
            b4 = ~b4;
        end
        unbal4 = ($countones(b4) != 2);
        flip4 = unbal4 || (b4 == 4'b1100) || k_bal;
        s4 = (rd_mid && flip4) ? ~b4 : b4;
        rd_end = rd_mid ^ unbal4;
        return {bad, rd_end, s6, s4};
    endfunction

    logic [10*LANES-1:0] enc_data, data_q;
    logic [LANES-1:0]    enc_err, err_q;
    logic [11:0]         lane_res;
    logic                rd_run, rd_q, rd_d;
    logic                out_valid_q, out_valid_d;
    logic                accept;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.code_err  = err_q;
    assign bus.rd_out    = rd_q;

    // Chain the running disparity through the lanes of the presented word
    always_comb begin
        enc_data = '0;
        enc_err  = '0;
        lane_res = '0;
        rd_run   = rd_q;
        for (int i = 0; i < LANES; i++) begin
            lane_res = enc_lane(bus.data_in[8*i +: 8], bus.k_in[i], rd_run);
            enc_data[10*i +: 10] = lane_res[9:0];
            enc_err[i] = lane_res[11];
            rd_run = lane_res[10];
        end
    end

    // Next-state for the output stage and running disparity
    always_comb begin
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            rd_d        = rd_run;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and running disparity; data only moves on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= '0;
            rd_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            if (accept) begin
                data_q <= enc_data;
                err_q  <= enc_err;
            end
        end
    end

endmodule

// File: tb/tb_encoder_8b_10b_multi.sv
// Self-checking bench for encoder_8b_10b_multi (LANES=2): directed vectors
// followed by a randomized D/K stream against an independent table model.
module tb_encoder_8b_10b_multi;

    localparam int LANES = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    encoder_8b_10b_multi_if #(.LANES(LANES)) bus ();

    encoder_8b_10b_multi #(.LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Full RD-/RD+ columns, abcdei and fghj order
    logic [5:0] d6_neg [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] d6_pos [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] d4_neg [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                               4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] d4_pos [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                               4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] k4_neg [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                               4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] k4_pos [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                               4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [7:0] k_list [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference for one lane: {rd_after, symbol}; disparity from ones count
    function automatic logic [10:0] model_lane(input logic [7:0] b, input logic k,
                                               input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       kv, r;
        logic [5:0] s6;
        logic [3:0] s4;
        x = b[4:0];
        y = b[7:5];
        kv = (x == 5'd28) || (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 ||
                                             x == 5'd30));
        if (k && !kv) begin
            x = 5'd28;
            y = 3'd5;
        end
        if (k && x == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
        else                 s6 = rd ? d6_pos[x] : d6_neg[x];
        r = rd;
        if ($countones(s6) > 3) r = 1'b1;
        else if ($countones(s6) < 3) r = 1'b0;
        if (k) s4 = r ? k4_pos[y] : k4_neg[y];
        else if (y == 3'd7 && ((!r && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                               (r && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
            s4 = r ? 4'b1000 : 4'b0111;
        else s4 = r ? d4_pos[y] : d4_neg[y];
        if ($countones(s4) > 2) r = 1'b1;
        else if ($countones(s4) < 2) r = 1'b0;
        return {r, s6, s4};
    endfunction

    task automatic model_word(input logic [15:0] d, input logic [1:0] k, input logic rd_in,
                              output logic [19:0] sym, output logic [1:0] err,
                              output logic rd_o);
        logic [10:0] res;
        logic [7:0]  b;
        logic        r;
        r = rd_in;
        sym = '0;
        err = '0;
        for (int i = 0; i < LANES; i++) begin
            b = d[8*i +: 8];
            res = model_lane(b, k[i], r);
            sym[10*i +: 10] = res[9:0];
            err[i] = k[i] && !(b[4:0] == 5'd28 || (b[7:5] == 3'd7 &&
                     (b[4:0] == 5'd23 || b[4:0] == 5'd27 || b[4:0] == 5'd29 ||
                      b[4:0] == 5'd30)));
            r = res[10];
        end
        rd_o = r;
    endtask

    // Called at posedge+1; presents one word for a single cycle with out_ready high
    task automatic xfer(input logic [15:0] d, input logic [1:0] k);
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.k_in      = k;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic [21:0] exp_q [$];
    logic [21:0] front;
    logic [19:0] m_sym;
    logic [1:0]  m_err;
    logic        m_rd, model_rd;
    logic [15:0] r_data;
    logic [1:0]  r_k;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.k_in      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_rd", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // D0.0 in both lanes from RD-
        xfer(16'h0000, 2'b00);
        check("d00_valid", 32'(bus.out_valid), 32'd1);
        check("d00_data", 32'(bus.data_out), {12'd0, 10'h274, 10'h274});
        check("d00_err", 32'(bus.code_err), 32'd0);
        check("d00_rd", 32'(bus.rd_out), 32'd0);

        // K28.5 both lanes: RD- then RD+
        xfer(16'hBCBC, 2'b11);
        check("k285_data", 32'(bus.data_out), {12'd0, 10'h305, 10'h0FA});
        check("k285_rd", 32'(bus.rd_out), 32'd0);

        // K28.5 then D21.5
        xfer(16'hB5BC, 2'b01);
        check("mix_data", 32'(bus.data_out), {12'd0, 10'h2AA, 10'h0FA});
        check("mix_rd", 32'(bus.rd_out), 32'd1);
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_data", 32'(bus.data_out), 32'd0);
        check("midrst_rd", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(bus.in_ready), 32'd1);

        // Invalid K0.0 in lane 0 after reset
        xfer(16'h0000, 2'b01);
        check("badk_data", 32'(bus.data_out), {12'd0, 10'h18B, 10'h0FA});
        check("badk_err", 32'(bus.code_err), 32'd1);
        check("badk_rd", 32'(bus.rd_out), 32'd1);

        // Backpressure with a pending input word
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 16'h0000;
        bus.k_in      = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.data_out), {12'd0, 10'h18B, 10'h0FA});
            check("stall_rd", 32'(bus.rd_out), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("release_valid", 32'(bus.out_valid), 32'd1);
        check("release_data", 32'(bus.data_out), {12'd0, 10'h18B, 10'h18B});
        check("release_rd", 32'(bus.rd_out), 32'd1);
        @(posedge clk);
        #1;
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        // Random stream with toggling backpressure, scoreboard in order
        model_rd = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            for (int l = 0; l < LANES; l++) begin
                r_k[l] = ($urandom_range(0, 3) == 0);
                if (r_k[l] && $urandom_range(0, 3) != 0)
                    r_data[8*l +: 8] = k_list[$urandom_range(0, 11)];
                else
                    r_data[8*l +: 8] = 8'($urandom_range(0, 255));
            end
            bus.data_in = r_data;
            bus.k_in    = r_k;
            @(negedge clk);
            check("rnd_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            check("rnd_rd", 32'(bus.rd_out), 32'(model_rd));
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                front = exp_q.pop_front();
                check("rnd_data", 32'(bus.data_out), 32'(front[19:0]));
                check("rnd_err", 32'(bus.code_err), 32'(front[21:20]));
            end
            if (bus.in_valid && bus.in_ready) begin
                model_word(r_data, r_k, model_rd, m_sym, m_err, m_rd);
                exp_q.push_back({m_err, m_sym});
                model_rd = m_rd;
            end
            @(posedge clk);
            #1;
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                front = exp_q.pop_front();
                check("tail_data", 32'(bus.data_out), 32'(front[19:0]));
            end
            @(posedge clk);
            #1;
        end
        check("tail_empty", 32'(exp_q.size()), 32'd0);
        check("tail_valid", 32'(bus.out_valid), 32'd0);
        check("tail_rd", 32'(bus.rd_out), 32'(model_rd));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
